// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped UART transmitter (TX FIFO + bit-serial 8N1 framer)
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous active-high reset
//   MemWrite   CPU store strobe
//   Addr       CPU byte address (ALUResult)
//   WriteData  CPU store data
//   Sel        Addr hits this 16-byte register window (combinational)
//   ReadData   register read data, 0 when not selected (combinational)
//   tx         serial output, idle high
// Register map (Addr[3:2]): 0 TXDATA (W), 1 STATUS (R, bit3 W1C ovf), 2 DIV (R/W), 3 reserved.
// Define UART_TX_PARITY_EN to add an even-parity bit between the data bits and the stop bit.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          FIFO_DEPTH   = 8,
    parameter int          CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Addr,
    input  logic [31:0] WriteData,
    output logic        Sel,
    output logic [31:0] ReadData,
    output logic        tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
    localparam logic PARITY_EN = 1'b1;
`else
    localparam logic PARITY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} stateType;

    stateType        state, stateNext;
    logic [7:0]      fifoMem [FIFO_DEPTH];
    logic [AW-1:0]   wrPtr, rdPtr;
    logic [6:0]      count;
    logic [15:0]     div, period, bitTimer;
    logic [2:0]      bitIdx;
    logic [7:0]      shiftReg;
    logic            parityBit, ovf;
    logic            wrEn, pushReq, pushOk, pop, full, empty, busy, bitDone;
    logic [31:0]     status;
    logic            unusedBits;

    assign Sel        = Addr[31:4] == BASE_ADDR[31:4];
    assign wrEn       = MemWrite & Sel;
    assign pushReq    = wrEn && Addr[3:2] == 2'd0;
    // full uses the registered count, so a push while full is dropped even if a pop happens this cycle
    assign full       = count == 7'(FIFO_DEPTH);
    assign empty      = count == 7'd0;
    assign pushOk     = pushReq & ~full;
    assign bitDone    = bitTimer == period - 16'd1;
    assign status     = {20'd0, PARITY_EN, count, ovf, empty, full, busy};
    assign ReadData   = !Sel ? 32'd0 : Addr[3:2] == 2'd1 ? status : Addr[3:2] == 2'd2 ? {16'd0, div} : 32'd0;
    assign unusedBits = ^{Addr[1:0], WriteData[31:16]};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= stateNext;
    end

    // pop coincides with entering START, from IDLE or straight from STOP (no idle gap)
    always_comb begin
        stateNext = state;
        pop       = 1'b0;
        busy      = 1'b1;
        tx        = 1'b1;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (!empty) begin
                    stateNext = START;
                    pop       = 1'b1;
                end
            end
            START: begin
                tx = 1'b0;
                if (bitDone) stateNext = DATA;
            end
            DATA: begin
                tx = shiftReg[0];
                if (bitDone && bitIdx == 3'd7) stateNext = PARITY_EN ? PARITY : STOP;
            end
            PARITY: begin
                tx = parityBit;
                if (bitDone) stateNext = STOP;
            end
            STOP: begin
                if (bitDone) begin
                    stateNext = empty ? IDLE : START;
                    pop       = !empty;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (pushOk) fifoMem[wrPtr] <= WriteData[7:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            div       <= 16'(CLKS_PER_BIT);
            period    <= 16'd1;
            bitTimer  <= '0;
            bitIdx    <= '0;
            shiftReg  <= '0;
            parityBit <= 1'b0;
        end else begin
            if (pushOk) wrPtr <= wrPtr + 1'b1;
            if (pop)    rdPtr <= rdPtr + 1'b1;
            count <= count + 7'(pushOk) - 7'(pop);
            // an overflow in the same cycle as the W1C clear wins
            ovf <= (pushReq & full) | (ovf & ~(wrEn && Addr[3:2] == 2'd1 && WriteData[3]));
            if (wrEn && Addr[3:2] == 2'd2) div <= WriteData[15:0];
            // the bit period is frozen per frame so DIV writes only affect later frames
            if (pop) begin
                bitTimer  <= '0;
                bitIdx    <= '0;
                period    <= div == 16'd0 ? 16'd1 : div;
                shiftReg  <= fifoMem[rdPtr];
                parityBit <= ^fifoMem[rdPtr];
            end else if (busy) begin
                bitTimer <= bitDone ? 16'd0 : bitTimer + 16'd1;
                if (state == DATA && bitDone) begin
                    shiftReg <= shiftReg >> 1;
                    bitIdx   <= bitIdx + 3'd1;
                end
            end
        end
    end
endmodule
